// File: rtl/io_server_pkg.sv
// Shared types for io_server: byte width (pkg_ram) plus drain FSM states and CR/LF codes (pkg_io).
package pkg_ram;
  localparam int RAM_BYTE_SIZE = 8;
endpackage

package pkg_io;
  typedef enum logic [1:0] {
    IO_IDLE    = 2'd0,
    IO_SEND    = 2'd1,
    IO_SEND_CR = 2'd2
  } io_tx_state_t;

  localparam logic [pkg_ram::RAM_BYTE_SIZE-1:0] IO_LF = 8'h0A;
  localparam logic [pkg_ram::RAM_BYTE_SIZE-1:0] IO_CR = 8'h0D;

  // True when the byte is a line feed that may need a CR in front of it.
  function automatic logic is_lf(input logic [pkg_ram::RAM_BYTE_SIZE-1:0] b);
    return (b == IO_LF);
  endfunction
endpackage

// File: rtl/io_server_if.sv
// if_io: CPU-side byte I/O link; the CPU is the client, io_server is the server.
interface if_io;
  logic                              getc_pop;
  logic                              putc_push;
  logic [pkg_ram::RAM_BYTE_SIZE-1:0] putc_char;
  logic                              inbuf_full;
  logic                              getc_en;
  logic [pkg_ram::RAM_BYTE_SIZE-1:0] getc_char;
  logic                              putc_push_done;

  modport server (
    input  getc_pop, putc_push, putc_char,
    output inbuf_full, getc_en, getc_char, putc_push_done
  );

  modport client (
    output getc_pop, putc_push, putc_char,
    input  inbuf_full, getc_en, getc_char, putc_push_done
  );
endinterface

// File: rtl/io_server_fifo.sv
// io_fifo: synchronous FIFO with pointer-compare full/empty and a combinational head (0 when empty).
// The caller gates push/pop; a push while full is legal only together with a pop.
module io_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         second,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW-1:0]    rd_idx_s;
  logic [AW-1:0]    rd_nx_idx_s;

  assign rd_idx_s    = rd_ptr_r[AW-1:0];
  assign rd_nx_idx_s = rd_ptr_r[AW-1:0] + AW'(1);
  assign empty       = (wr_ptr_r == rd_ptr_r);
  assign full        = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count       = wr_ptr_r - rd_ptr_r;
  assign dout        = empty ? {WIDTH{1'b0}} : mem_r[rd_idx_s];
  assign second      = mem_r[rd_nx_idx_s];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end
endmodule

// File: rtl/io_server.sv
// io_server: buffers UART rx bytes for getc and drains putc bytes to the UART tx.
// Optional macro IO_CRLF_EN: every LF is sent to the transmitter as CR followed by LF.
module io_server
  import pkg_io::*;
#(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  if_io.server                              io,
  input  logic                              rx_valid,
  input  logic [pkg_ram::RAM_BYTE_SIZE-1:0] rx_byte,
  output logic                              rx_overrun,
  output logic                              tx_valid,
  output logic [pkg_ram::RAM_BYTE_SIZE-1:0] tx_byte,
  input  logic                              tx_ready
);
  localparam int BW     = pkg_ram::RAM_BYTE_SIZE;
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
`ifdef IO_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic              in_push_s, in_pop_s, in_empty_s, in_full_s;
  logic [BW-1:0]     in_head_s, in_second_s;
  logic [IN_AW:0]    in_count_s;
  logic              out_push_s, out_pop_s, out_empty_s, out_full_s;
  logic [BW-1:0]     out_head_s, out_second_s, next_head_s;
  logic [OUT_AW:0]   out_count_s;
  logic              more_s;
  logic              overrun_r, push_done_r, push_held_r;
  logic              tx_valid_s;
  logic [BW-1:0]     tx_byte_s;
  io_tx_state_t      state_r, state_nx_s;

  // First state used to send a byte: LFs get a CR in front when CRLF is enabled.
  function automatic io_tx_state_t send_state(input logic [BW-1:0] b);
    return (CRLF && is_lf(b)) ? IO_SEND_CR : IO_SEND;
  endfunction

  // A pop frees a slot in the same cycle, so rx into a full FIFO is kept when paired with a pop.
  assign in_pop_s  = io.getc_pop && !in_empty_s;
  assign in_push_s = rx_valid && (!in_full_s || in_pop_s);

  io_fifo #(.DEPTH(IN_DEPTH), .WIDTH(BW)) u_in_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (in_push_s),
    .pop    (in_pop_s),
    .din    (rx_byte),
    .dout   (in_head_s),
    .second (in_second_s),
    .count  (in_count_s),
    .empty  (in_empty_s),
    .full   (in_full_s)
  );

  assign io.getc_en        = !in_empty_s;
  assign io.getc_char      = in_head_s;
  assign io.inbuf_full     = (in_count_s == (IN_AW+1)'(IN_DEPTH));
  assign io.putc_push_done = push_done_r;
  assign rx_overrun        = overrun_r;

  // A held push is written once; the client must drop push before the next request is taken.
  assign out_push_s = io.putc_push && !out_full_s && !push_done_r && !push_held_r;

  io_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(BW)) u_out_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (out_push_s),
    .pop    (out_pop_s),
    .din    (io.putc_char),
    .dout   (out_head_s),
    .second (out_second_s),
    .count  (out_count_s),
    .empty  (out_empty_s),
    .full   (out_full_s)
  );

  // Byte that becomes the head after the current one is popped (may be the one being written now).
  assign more_s      = (out_count_s > (OUT_AW+1)'(1)) || out_push_s;
  assign next_head_s = (out_count_s > (OUT_AW+1)'(1)) ? out_second_s : io.putc_char;

  // Overrun flag, putc handshake and drain state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r   <= 1'b0;
      push_done_r <= 1'b0;
      push_held_r <= 1'b0;
      state_r     <= IO_IDLE;
    end else begin
      if (rx_valid && !in_push_s) overrun_r <= 1'b1;
      push_done_r <= out_push_s;
      if (out_push_s)         push_held_r <= 1'b1;
      else if (!io.putc_push) push_held_r <= 1'b0;
      state_r <= state_nx_s;
    end
  end

  // Drain FSM next-state and transmitter offer.
  always_comb begin
    state_nx_s = state_r;
    out_pop_s  = 1'b0;
    tx_valid_s = 1'b0;
    tx_byte_s  = {BW{1'b0}};
    case (state_r)
      IO_IDLE: begin
        if (!out_empty_s) state_nx_s = send_state(out_head_s);
        else              state_nx_s = IO_IDLE;
      end
      IO_SEND: begin
        tx_valid_s = 1'b1;
        tx_byte_s  = out_head_s;
        if (tx_ready) begin
          out_pop_s = 1'b1;
          if (more_s) state_nx_s = send_state(next_head_s);
          else        state_nx_s = IO_IDLE;
        end else begin
          state_nx_s = IO_SEND;
        end
      end
`ifdef IO_CRLF_EN
      IO_SEND_CR: begin
        tx_valid_s = 1'b1;
        tx_byte_s  = IO_CR;
        if (tx_ready) state_nx_s = IO_SEND;
        else          state_nx_s = IO_SEND_CR;
      end
`endif
      default: state_nx_s = IO_IDLE;
    endcase
  end

  assign tx_valid = tx_valid_s;
  assign tx_byte  = tx_byte_s;
endmodule

// File: tb/tb_io_server.sv
// Randomised scoreboard bench for io_server; define IO_CRLF_EN in both builds to cover CR/LF expansion.
`timescale 1ns/1ps
module tb_io_server;
  import pkg_io::*;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_overrun;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready = 1'b0;

  if_io io();

  io_server #(.IN_DEPTH(DEPTH), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_overrun(rx_overrun),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] in_exp_q[$];
  logic [7:0] tx_exp_q[$];
  int  m_in_cnt = 0;
  bit  m_ovr = 1'b0;
  bit  snap_en = 1'b0, snap_full = 1'b0, snap_ovr = 1'b0;
  bit  mon_en = 1'b0;
  int  p_rx, p_pop, p_push, p_ready, hold_max;
  int  cl_state = 0, hold_left = 0, issued = 0, done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model snapshot and the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk); #4;
      if (mon_en) begin
        chk("getc_en", int'(io.getc_en), int'(snap_en));
        chk("inbuf_full", int'(io.inbuf_full), int'(snap_full));
        chk("rx_overrun", int'(rx_overrun), int'(snap_ovr));
        if (!io.getc_en) chk("getc_char_empty", int'(io.getc_char), 0);
        if (io.getc_pop && io.getc_en) begin
          if (in_exp_q.size() == 0) chk("getc_extra", 1, 0);
          else chk("getc_char", int'(io.getc_char), int'(in_exp_q.pop_front()));
        end
        if (tx_valid && tx_ready) begin
          if (tx_exp_q.size() == 0) chk("tx_extra", 1, 0);
          else chk("tx_byte", int'(tx_byte), int'(tx_exp_q.pop_front()));
        end
      end
    end
  end

  // One cycle of stimulus; the reference model is updated for the edge that follows.
  task automatic step();
    bit pop_eff, acc;
    logic [7:0] c;
    @(negedge clk); #2;
    snap_en   = (m_in_cnt > 0);
    snap_full = (m_in_cnt == DEPTH);
    snap_ovr  = m_ovr;
    rx_valid    = ($urandom_range(99, 0) < p_rx);
    rx_byte     = 8'($urandom_range(255, 0));
    io.getc_pop = ($urandom_range(99, 0) < p_pop);
    pop_eff = io.getc_pop && (m_in_cnt > 0);
    acc     = rx_valid && ((m_in_cnt < DEPTH) || pop_eff);
    if (acc) in_exp_q.push_back(rx_byte);
    else if (rx_valid) m_ovr = 1'b1;
    m_in_cnt = m_in_cnt + int'(acc) - int'(pop_eff);
    tx_ready = ($urandom_range(99, 0) < p_ready);
    case (cl_state)
      0: begin
        chk("done_idle", int'(io.putc_push_done), 0);
        io.putc_push = 1'b0;
        if ($urandom_range(99, 0) < p_push) begin
          c = ($urandom_range(3, 0) == 0) ? IO_LF : 8'($urandom_range(255, 0));
          io.putc_char = c;
          io.putc_push = 1'b1;
          issued++;
`ifdef IO_CRLF_EN
          if (c == IO_LF) tx_exp_q.push_back(IO_CR);
`endif
          tx_exp_q.push_back(c);
          cl_state = 1;
        end
      end
      1: begin
        if (io.putc_push_done) begin
          done_cnt++;
          hold_left = (hold_max > 0) ? $urandom_range(hold_max, 0) : 0;
          if (hold_left == 0) begin
            io.putc_push = 1'b0;
            cl_state = 0;
          end else begin
            cl_state = 2;
          end
        end
      end
      2: begin
        chk("done_while_held", int'(io.putc_push_done), 0);
        hold_left--;
        if (hold_left == 0) begin
          io.putc_push = 1'b0;
          cl_state = 0;
        end
      end
      default: cl_state = 0;
    endcase
  endtask

  task automatic knobs(input int rx, input int pop, input int push, input int rdy, input int hm);
    p_rx = rx; p_pop = pop; p_push = push; p_ready = rdy; hold_max = hm;
  endtask

  initial begin
    int d0, sz;
    io.getc_pop = 1'b0; io.putc_push = 1'b0; io.putc_char = 8'h00;
    #3;
    chk("rst_getc_en", int'(io.getc_en), 0);
    chk("rst_getc_char", int'(io.getc_char), 0);
    chk("rst_inbuf_full", int'(io.inbuf_full), 0);
    chk("rst_done", int'(io.putc_push_done), 0);
    chk("rst_overrun", int'(rx_overrun), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Random traffic with varied rates and push hold times.
    for (int ph = 0; ph < 6; ph++) begin
      knobs($urandom_range(90, 10), $urandom_range(90, 10), $urandom_range(90, 20),
            $urandom_range(100, 10), $urandom_range(3, 0));
      repeat (150) step();
    end
    knobs(0, 100, 0, 100, 0);
    repeat (60) step();

    // Transmitter stalled: exactly DEPTH pushes complete, the next one waits.
    knobs(0, 0, 100, 0, 3);
    d0 = done_cnt;
    repeat (90) step();
    chk("stall_accepts", done_cnt - d0, DEPTH);
    chk("stall_pending", cl_state, 1);

    // Release the transmitter: the queue must drain one byte per cycle.
    knobs(0, 0, 0, 100, 0);
    sz = tx_exp_q.size();
    repeat (sz + 3) step();
    chk("drain_no_bubble", tx_exp_q.size(), 0);

    // Input overrun, then rx with pop while full (no loss).
    knobs(100, 0, 100, 0, 0);
    repeat (40) step();
    knobs(100, 100, 0, 0, 0);
    repeat (10) step();

    // Asynchronous reset in the middle of a stalled drain.
    @(negedge clk); #2;
    mon_en = 1'b0;
    chk("pre_rst_tx_valid", int'(tx_valid), 1);
    chk("pre_rst_overrun", int'(rx_overrun), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", int'(tx_valid), 0);
    chk("mid_rst_tx_byte", int'(tx_byte), 0);
    chk("mid_rst_getc_en", int'(io.getc_en), 0);
    chk("mid_rst_inbuf_full", int'(io.inbuf_full), 0);
    chk("mid_rst_overrun", int'(rx_overrun), 0);
    chk("mid_rst_done", int'(io.putc_push_done), 0);
    rx_valid = 1'b0; io.getc_pop = 1'b0; io.putc_push = 1'b0; tx_ready = 1'b0;
    in_exp_q.delete(); tx_exp_q.delete();
    m_in_cnt = 0; m_ovr = 1'b0; cl_state = 0; issued = 0; done_cnt = 0;
    repeat (2) @(negedge clk);
    #2;
    snap_en = 1'b0; snap_full = 1'b0; snap_ovr = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int ph = 0; ph < 3; ph++) begin
      knobs($urandom_range(90, 10), $urandom_range(90, 10), $urandom_range(90, 20),
            $urandom_range(100, 10), $urandom_range(3, 0));
      repeat (150) step();
    end

    // Final drain: everything issued must have come out exactly once.
    knobs(0, 100, 0, 100, 0);
    repeat (100) step();
    chk("end_in_q_empty", in_exp_q.size(), 0);
    chk("end_tx_q_empty", tx_exp_q.size(), 0);
    chk("end_done_count", done_cnt, issued);
    chk("end_client_idle", cl_state, 0);
    chk("end_tx_valid", int'(tx_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
